lstm_sequence_controller: RTL and testbench

Sequencer placed in front of the multi-layer LSTM datapath. It accepts a stream of input samples, clears per-layer cell and hidden state at the start of each sequence, and issues one sample at a time to the recurrent datapath, waiting for each result before issuing the next. Results are buffered in a small output FIFO, tagged with end-of-sequence, and presented as a ready/valid stream. Host-side weight loading stays on the AXI4-Lite path; this block drives only the datapath's state and x inputs.

---
 rtl/lstm_sequence_controller_pkg.sv | 15 +
 rtl/lstm_result_fifo.sv | 82 ++++++++
 rtl/lstm_sequence_controller.sv | 132 +++++++++++++
 tb/tb_lstm_sequence_controller.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_sequence_controller_pkg.sv
// lstm_pkg -- shared types and constants for the LSTM sequence controller.
//   lstm_seq_state_t : sequencer FSM states (IDLE, CLEAR, ISSUE, WAIT)
//   LSTM_DATA_WIDTH  : default sample/state width of the datapath
package lstm_pkg;

  localparam int LSTM_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } lstm_seq_state_t;

endpackage

// File: rtl/lstm_result_fifo.sv
// lstm_result_fifo -- synchronous first-word fall-through FIFO with a
// registered output stage.
//   clk, rst          : clock, synchronous active-high reset (empties FIFO)
//   push, push_data   : write strobe and word
//   pop_data/pop_valid: registered head of queue
//   pop               : consume head (ignored while pop_valid is low)
//   count             : number of stored words (0..DEPTH)
module lstm_result_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;

  logic             pop_eff;
  logic             push_eff;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      after_pop;
  logic [AW:0]      count_next;

  assign pop_eff     = pop && out_valid_reg;
  // A word can always be written when a pop frees a slot in the same cycle.
  assign push_eff    = push && ((count_reg != FULL) || pop_eff);
  assign rd_ptr_next = rd_ptr_reg + AW'(pop_eff);
  assign after_pop   = count_reg - (AW+1)'(pop_eff);
  assign count_next  = after_pop + (AW+1)'(push_eff);

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // The output register always mirrors the head of the ring. When the ring
  // drains to empty in the same cycle a word arrives, that word bypasses the
  // array so it appears one cycle after the push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (push_eff) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      out_valid_reg <= (count_next != '0);
      if (count_next != '0) begin
        if (after_pop == '0) begin
          out_data_reg <= push_data;
        end else begin
          out_data_reg <= mem[rd_ptr_next];
        end
      end
    end
  end

  assign pop_data  = out_data_reg;
  assign pop_valid = out_valid_reg;
  assign count     = count_reg;

endmodule

// File: rtl/lstm_sequence_controller.sv
// lstm_sequence_controller -- feeds samples one at a time into a recurrent
// multi-layer LSTM datapath and buffers its results.
//   s_x_*            : input sample stream (first clears state, last tags result)
//   lstm_ready       : datapath can accept writes
//   lstm_state_in    : zero value used for C/h clears
//   lstm_C/h_in_valid: per-layer clear strobes (all layers together)
//   lstm_x_in(_valid): sample issue to the datapath
//   lstm_y_out/valid : datapath result
//   m_y_*            : buffered result stream with end-of-sequence flag
//   seq_count        : completed sequences, err_unexpected: stray result seen
//   busy             : a sample is being processed
module lstm_sequence_controller
  import lstm_pkg::*;
#(
  parameter int LAYERS    = 4,
  parameter int WIDTH     = LSTM_DATA_WIDTH,
  parameter int OUT_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          s_x_data,
  input  logic                      s_x_first,
  input  logic                      s_x_last,
  input  logic                      s_x_valid,
  output logic                      s_x_ready,
  input  logic                      lstm_ready,
  output logic [LAYERS*WIDTH-1:0]   lstm_state_in,
  output logic [LAYERS-1:0]         lstm_C_in_valid,
  output logic [LAYERS-1:0]         lstm_h_in_valid,
  output logic [WIDTH-1:0]          lstm_x_in,
  output logic                      lstm_x_in_valid,
  input  logic [WIDTH-1:0]          lstm_y_out,
  input  logic                      lstm_valid,
  output logic [WIDTH-1:0]          m_y_data,
  output logic                      m_y_last,
  output logic                      m_y_valid,
  input  logic                      m_y_ready,
  output logic [31:0]               seq_count,
  output logic                      err_unexpected,
  output logic                      busy
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(OUT_DEPTH);

  lstm_seq_state_t  state_reg, state_next;
  logic [WIDTH-1:0] x_reg;
  logic             last_reg;
  logic [31:0]      seq_count_reg;
  logic             err_reg;

  logic             accept;
  logic             clear_fire;
  logic             issue_fire;
  logic             result_fire;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH:0]   fifo_out;

  // Space is checked at accept time; since only one sample is ever in
  // flight, the slot it needs stays free until its result arrives.
  assign s_x_ready   = (state_reg == IDLE) && (fifo_count < FULL_COUNT) && !rst;
  assign accept      = s_x_valid && s_x_ready;
  assign clear_fire  = (state_reg == CLEAR) && lstm_ready;
  assign issue_fire  = (state_reg == ISSUE) && lstm_ready;
  assign result_fire = (state_reg == WAIT) && lstm_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = s_x_first ? CLEAR : ISSUE;
      CLEAR: if (clear_fire) state_next = ISSUE;
      ISSUE: if (issue_fire) state_next = WAIT;
      WAIT:  if (result_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      last_reg      <= 1'b0;
      seq_count_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        x_reg    <= s_x_data;
        last_reg <= s_x_last;
      end
      if (result_fire && last_reg) begin
        seq_count_reg <= seq_count_reg + 32'd1;
      end
      if (lstm_valid && (state_reg != WAIT)) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Every layer is cleared in the same cycle with a zero state value.
  generate
    for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
      assign lstm_state_in[gi*WIDTH +: WIDTH] = '0;
      assign lstm_C_in_valid[gi]              = clear_fire;
      assign lstm_h_in_valid[gi]              = clear_fire;
    end
  endgenerate

  assign lstm_x_in       = x_reg;
  assign lstm_x_in_valid = issue_fire;

  lstm_result_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (result_fire),
    .push_data ({lstm_y_out, last_reg}),
    .pop       (m_y_ready),
    .pop_data  (fifo_out),
    .pop_valid (m_y_valid),
    .count     (fifo_count)
  );

  assign m_y_data       = fifo_out[WIDTH:1];
  assign m_y_last       = fifo_out[0];
  assign seq_count      = seq_count_reg;
  assign err_unexpected = err_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_lstm_sequence_controller.sv
// Testbench for lstm_sequence_controller: a behavioural datapath stand-in
// (y = x + h + K, h cleared by the clear strobes), a reference model that
// predicts each result from the accepted samples, and a scoreboard monitor.
module tb_lstm_sequence_controller;

  localparam int LAYERS = 4;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 4;
  localparam logic [15:0] K = 16'h1134;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [WIDTH-1:0]        s_x_data = '0;
  logic                    s_x_first = 1'b0;
  logic                    s_x_last = 1'b0;
  logic                    s_x_valid = 1'b0;
  logic                    s_x_ready;
  logic                    lstm_ready = 1'b1;
  logic [LAYERS*WIDTH-1:0] lstm_state_in;
  logic [LAYERS-1:0]       lstm_C_in_valid;
  logic [LAYERS-1:0]       lstm_h_in_valid;
  logic [WIDTH-1:0]        lstm_x_in;
  logic                    lstm_x_in_valid;
  logic [WIDTH-1:0]        lstm_y_out = '0;
  logic                    lstm_valid = 1'b0;
  logic [WIDTH-1:0]        m_y_data;
  logic                    m_y_last;
  logic                    m_y_valid;
  logic                    m_y_ready = 1'b1;
  logic [31:0]             seq_count;
  logic                    err_unexpected;
  logic                    busy;

  lstm_sequence_controller #(.LAYERS(LAYERS), .WIDTH(WIDTH), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_x_data(s_x_data), .s_x_first(s_x_first), .s_x_last(s_x_last),
    .s_x_valid(s_x_valid), .s_x_ready(s_x_ready),
    .lstm_ready(lstm_ready), .lstm_state_in(lstm_state_in),
    .lstm_C_in_valid(lstm_C_in_valid), .lstm_h_in_valid(lstm_h_in_valid),
    .lstm_x_in(lstm_x_in), .lstm_x_in_valid(lstm_x_in_valid),
    .lstm_y_out(lstm_y_out), .lstm_valid(lstm_valid),
    .m_y_data(m_y_data), .m_y_last(m_y_last), .m_y_valid(m_y_valid), .m_y_ready(m_y_ready),
    .seq_count(seq_count), .err_unexpected(err_unexpected), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out or no expected entry", name);
  endtask

  // Reference model state
  typedef struct { logic [15:0] y; logic last; } res_t;
  typedef struct { logic [15:0] x; logic first; } iss_t;
  res_t        exp_q[$];
  iss_t        iss_q[$];
  logic [15:0] model_h = '0;
  int          model_seq = 0;

  // Environment knobs
  int ready_mode = 0;   // 0 high, 1 random, 2 low
  int m_mode = 1;       // 0 low, 1 high, 2 random
  int fixed_lat = 1;
  bit rand_lat = 0;
  bit inject_spurious = 0;

  // Datapath observation
  int clears = 0, issues = 0, pops = 0;
  int acc_cyc = 0, last_clear_cyc = -1, last_issue_cyc = -1;
  logic [15:0] last_pop_data = '0;
  logic        last_pop_last = 1'b0;

  // Behavioural datapath
  int          pend = 0;
  logic [15:0] pend_y = '0;
  logic [15:0] dp_h = '0;
  bit          clear_seen = 0;

  always @(negedge clk) begin
    lstm_valid = 1'b0;
    if (inject_spurious) lstm_valid = 1'b1;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        lstm_valid = 1'b1;
        lstm_y_out = pend_y;
      end
    end
    case (ready_mode)
      0: lstm_ready = 1'b1;
      1: lstm_ready = ($urandom_range(0, 2) != 0);
      default: lstm_ready = 1'b0;
    endcase
    #1;
    if (rst) begin
      pend = 0;
      dp_h = '0;
      clear_seen = 0;
    end else begin
      if ((|lstm_C_in_valid) || (|lstm_h_in_valid)) begin
        check("clear_needs_ready", lstm_ready, 1'b1);
        check("clear_C_all", lstm_C_in_valid, {LAYERS{1'b1}});
        check("clear_h_all", lstm_h_in_valid, {LAYERS{1'b1}});
        check("clear_state_zero", lstm_state_in, '0);
        dp_h = '0;
        clears++;
        clear_seen = 1;
        last_clear_cyc = cyc;
      end
      if (lstm_x_in_valid) begin
        iss_t e;
        check("issue_needs_ready", lstm_ready, 1'b1);
        if (iss_q.size() == 0) begin
          fail("issue_unexpected");
        end else begin
          e = iss_q.pop_front();
          check("issue_x", lstm_x_in, e.x);
          check("issue_cleared_iff_first", clear_seen, e.first);
        end
        pend_y = lstm_x_in + dp_h + K;
        dp_h = pend_y;
        pend = rand_lat ? $urandom_range(1, 4) : fixed_lat;
        issues++;
        last_issue_cyc = cyc;
        clear_seen = 0;
      end
    end
  end

  // Scoreboard monitor
  bit          stall_prev = 0;
  logic [15:0] stall_data = '0;
  logic        stall_last = 1'b0;

  always @(negedge clk) begin
    case (m_mode)
      0: m_y_ready = 1'b0;
      1: m_y_ready = 1'b1;
      default: m_y_ready = 1'($urandom_range(0, 1));
    endcase
    #2;
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", m_y_valid, 1'b1);
        check("stall_data_stable", m_y_data, stall_data);
        check("stall_last_stable", m_y_last, stall_last);
      end
      if (m_y_valid && m_y_ready) begin
        res_t r;
        if (exp_q.size() == 0) begin
          fail("output_unexpected");
        end else begin
          r = exp_q.pop_front();
          check("out_data", m_y_data, r.y);
          check("out_last", m_y_last, r.last);
          $display("out: data=0x%04h last=%0d", m_y_data, m_y_last);
        end
        pops++;
        last_pop_data = m_y_data;
        last_pop_last = m_y_last;
      end
      stall_prev = m_y_valid && !m_y_ready;
      stall_data = m_y_data;
      stall_last = m_y_last;
    end
  end

  task automatic send(input logic [15:0] x, input logic f, input logic l);
    int n = 0;
    bit done = 0;
    @(negedge clk);
    s_x_data = x; s_x_first = f; s_x_last = l; s_x_valid = 1'b1;
    while (!done) begin
      #1;
      if (s_x_ready) begin
        acc_cyc = cyc;
        if (f) model_h = '0;
        model_h = x + model_h + K;
        exp_q.push_back('{model_h, l});
        iss_q.push_back('{x, f});
        if (l) model_seq++;
        $display("in: x=0x%04h first=%0d last=%0d", x, f, l);
        @(posedge clk);
        #1 s_x_valid = 1'b0;
        done = 1;
      end else if (++n > 300) begin
        fail("send_accept");
        s_x_valid = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while (busy && n < 500);
    if (busy) fail("wait_idle");
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while ((busy || m_y_valid || exp_q.size() != 0) && n < 3000);
    if (busy || m_y_valid || exp_q.size() != 0) fail("wait_drain");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    model_h = '0;
    model_seq = 0;
    @(negedge clk);
    rst = 1'b0;
    #3;
  endtask

  initial begin
    int c0, i0, p0, n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    check("rst_C", lstm_C_in_valid, '0);
    check("rst_h", lstm_h_in_valid, '0);
    check("rst_x_valid", lstm_x_in_valid, 1'b0);
    check("rst_x_in", lstm_x_in, '0);
    check("rst_m_valid", m_y_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_seq", seq_count, 32'd0);
    check("rst_err", err_unexpected, 1'b0);
    check("rst_s_ready", s_x_ready, 1'b1);

    // Single first+last sample
    fixed_lat = 3;
    send(16'h0100, 1'b1, 1'b1);
    wait_drain();
    check("single_clear_cycle", last_clear_cyc, acc_cyc + 1);
    check("single_issue_cycle", last_issue_cyc, acc_cyc + 2);
    check("single_out_data", last_pop_data, 16'h1234);
    check("single_out_last", last_pop_last, 1'b1);
    check("single_seq", seq_count, 32'd1);

    // Non-first sample issues one cycle after accept
    fixed_lat = 1;
    send(16'h0042, 1'b0, 1'b0);
    wait_drain();
    check("nonfirst_issue_cycle", last_issue_cyc, acc_cyc + 1);

    // Three-sample sequence: exactly one clear
    c0 = clears;
    send(16'h0001, 1'b1, 1'b0);
    send(16'h0002, 1'b0, 1'b0);
    send(16'h0003, 1'b0, 1'b1);
    wait_drain();
    check("seq3_one_clear", clears - c0, 1);
    check("seq3_seq_count", seq_count, model_seq);

    // Output backpressure: four results fill the FIFO
    m_mode = 0;
    p0 = pops;
    send(16'h0A00, 1'b1, 1'b0);
    send(16'h0A01, 1'b0, 1'b0);
    send(16'h0A02, 1'b0, 1'b0);
    send(16'h0A03, 1'b0, 1'b0);
    wait_idle();
    check("full_s_ready_low", s_x_ready, 1'b0);
    check("full_m_valid", m_y_valid, 1'b1);
    check("full_no_pops", pops - p0, 0);
    fork
      begin
        repeat (5) @(negedge clk);
        m_mode = 1;
      end
      begin
        send(16'h0A04, 1'b0, 1'b0);
        send(16'h0A05, 1'b0, 1'b1);
      end
    join
    wait_drain();
    check("full_all_delivered", pops - p0, 6);

    // lstm_ready low while in CLEAR
    ready_mode = 2;
    c0 = clears;
    i0 = issues;
    send(16'h0777, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    #3;
    check("stall_no_clear", clears - c0, 0);
    check("stall_no_issue", issues - i0, 0);
    check("stall_busy", busy, 1'b1);
    ready_mode = 0;
    wait_drain();
    check("stall_clear_once", clears - c0, 1);
    check("stall_issue_once", issues - i0, 1);
    check("stall_clear_then_issue", last_issue_cyc, last_clear_cyc + 1);

    // Randomized traffic
    ready_mode = 1;
    m_mode = 2;
    rand_lat = 1;
    for (int i = 0; i < 40; i++) begin
      logic f, l;
      f = (i == 0) || ($urandom_range(0, 3) == 0);
      l = (i == 39) || ($urandom_range(0, 3) == 0);
      send(16'($urandom), f, l);
    end
    m_mode = 1;
    wait_drain();
    ready_mode = 0;
    check("rand_seq_count", seq_count, model_seq);
    check("rand_no_err", err_unexpected, 1'b0);

    // Reset while waiting for a result
    rand_lat = 0;
    fixed_lat = 20;
    i0 = issues;
    send(16'h0555, 1'b0, 1'b1);
    n = 0;
    while (issues == i0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (issues == i0) fail("wait_issue");
    repeat (2) @(negedge clk);
    #3;
    check("wait_busy", busy, 1'b1);
    do_reset();
    check("rstwait_busy", busy, 1'b0);
    check("rstwait_m_valid", m_y_valid, 1'b0);
    check("rstwait_seq", seq_count, 32'd0);
    check("rstwait_err", err_unexpected, 1'b0);

    // Late / spurious result in IDLE
    inject_spurious = 1;
    @(negedge clk); #3;
    inject_spurious = 0;
    @(negedge clk); #3;
    check("spur_err", err_unexpected, 1'b1);
    check("spur_m_valid", m_y_valid, 1'b0);
    check("spur_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    #3;
    check("spur_err_sticky", err_unexpected, 1'b1);
    do_reset();
    check("spur_err_cleared", err_unexpected, 1'b0);
    check("spur_s_ready", s_x_ready, 1'b1);

    // Normal operation after reset
    fixed_lat = 2;
    send(16'h0010, 1'b1, 1'b1);
    wait_drain();
    check("post_rst_seq", seq_count, 32'd1);
    check("post_rst_data", last_pop_data, 16'h0010 + K);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
